pong_score_keeper: RTL
======================

// Module: pong_score_keeper
// PURPOSE
//   Downstream end of the pong game state machine: consumes its p1score/p2score point strobes.
//   Keeps per-player point counts, declares a match winner at WIN_SCORE and enforces an
//   inter-point hold. Gates the player's serve request back into the game state machine.
//   Sits between the game state machine, the board buttons and the score display.
// PARAMETERS
//   SCORE_W     4   width of each point counter
//   WIN_SCORE   7   points that end the match; 1..2**SCORE_W-1
//   HOLD_TICKS  3   tick strobes in POINT before serving re-enables; 1..255
// PORTS
//   clk        in   1        system clock, all logic on posedge
//   rst        in   1        asynchronous, active-high reset
//   tick       in   1        one-cycle game-rate strobe, same source as the game SM ready input
//   p1score    in   1        player-1 point level from game SM, synchronous to clk
//   p2score    in   1        player-2 point level from game SM, synchronous to clk
//   serve_btn  in   1        debounced, synchronous serve request from player
//   new_game   in   1        debounced, synchronous match-restart request
//   serve      out  1        gated serve strobe, drives game SM serve input
//   p1_pts     out  SCORE_W  player-1 points
//   p2_pts     out  SCORE_W  player-2 points
//   game_over  out  1        high while in OVER
//   winner     out  2        00 none, 01 player 1, 10 player 2
//   fault      out  1        sticky: both score inputs rose in the same cycle
// BEHAVIOUR
//   Reset (async, rst=1): state=PLAY; p1_pts=p2_pts=0; serve=0; game_over=0; winner=00;
//     fault=0; hold_cnt=0; edge registers p1_d=p2_d=0.
//   Edge detection: p1_d<=p1score, p2_d<=p2score every clk.
//     e1=p1score&~p1_d and e2=p2score&~p2_d. A level held many cycles counts exactly once.
//   States: PLAY, POINT, OVER (2-bit encoded).
//   PLAY:
//     - e1 only: p1_pts<=p1_pts+1 on this edge (visible 1 clk after p1score rises).
//       If p1_pts+1==WIN_SCORE then OVER, winner<=01. Otherwise POINT, hold_cnt<=0.
//     - e2 only: symmetric, updating p2_pts and setting winner<=10.
//     - e1&e2: no count, fault<=1, stay in PLAY.
//     - serve<=serve_btn. This is a registered 1-clk latency path; a held button repeats serve.
//   POINT:
//     - serve<=0. Score edges here are ignored and are not counted.
//     - Each tick does hold_cnt++. When a tick arrives with hold_cnt==HOLD_TICKS-1, go to PLAY.
//   OVER:
//     - game_over=1, serve<=0, counts frozen, score edges ignored.
//     - new_game=1: p1_pts=p2_pts=0, winner<=00, go to PLAY. fault is not cleared.
//   new_game in PLAY or POINT: clears both counts and hold_cnt, goes to PLAY. winner stays 00.
//     new_game has priority over a same-cycle score edge, and that edge is dropped.
//   Counter width: compare uses SCORE_W+1 bits, so there is no wrap. OVER is reached before overflow.
//   game_over is decoded from state (combinational, glitch-free from registered state).
//   All other outputs are registered.
//   Reset mid-point or mid-hold: everything returns to reset values immediately.
//   The next clk edge after rst falls resumes in PLAY.
// TESTING
//   1) Reset, then p1score high 5 clks -> p1_pts=1 exactly once. State POINT, serve stays 0.
//   2) In POINT send 3 ticks with serve_btn held -> PLAY after 3rd tick.
//      serve=1 on the following clk.
//   3) Drive 7 p2 points (WIN_SCORE=7) -> p2_pts=7, game_over=1, winner=10.
//      Further p1score edges leave p1_pts unchanged.
//   4) p1score and p2score rise on the same clk in PLAY -> counts unchanged, fault=1 (sticky).
//   5) In OVER pulse new_game -> p1_pts=p2_pts=0, winner=00, game_over=0 next clk.
//   6) Assert rst mid-hold (hold_cnt=1, p1_pts=3) -> all outputs 0 asynchronously.
//      State PLAY after release.

Source files
------------

// File: rtl/pong_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : pong_score_keeper
// Purpose  : Counts the points reported by the pong game state machine and
//            declares the match winner at WIN_SCORE. After each point it
//            holds for HOLD_TICKS tick strobes, and it passes the player's
//            serve request to the game state machine only while play is open.
// Revision : 1.0  initial release
// ============================================================================
module pong_score_keeper #(
  parameter int SCORE_W    = 4,
  parameter int WIN_SCORE  = 7,
  parameter int HOLD_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               p1score,
  input  logic               p2score,
  input  logic               serve_btn,
  input  logic               new_game,
  output logic               serve,
  output logic [SCORE_W-1:0] p1_pts,
  output logic [SCORE_W-1:0] p2_pts,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               fault
);

  // Match phases
  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_POINT = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // The winning total is held one bit wider than the counters, so the
  // compare against count+1 cannot be fooled by a counter wrap.
  localparam logic [SCORE_W:0] c_win_score = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [7:0]       c_hold_last = 8'(HOLD_TICKS - 1);

  logic [1:0]         r_state;
  logic               r_p1_d;
  logic               r_p2_d;
  logic [7:0]         r_hold_cnt;
  logic [SCORE_W-1:0] r_p1_pts;
  logic [SCORE_W-1:0] r_p2_pts;
  logic               r_serve;
  logic [1:0]         r_winner;
  logic               r_fault;

  logic               w_e1;
  logic               w_e2;
  logic [SCORE_W:0]   w_p1_inc;
  logic [SCORE_W:0]   w_p2_inc;

  // A score level held high for several cycles counts only on its first cycle
  assign w_e1 = p1score & ~r_p1_d;
  assign w_e2 = p2score & ~r_p2_d;

  assign w_p1_inc = {1'b0, r_p1_pts} + {{SCORE_W{1'b0}}, 1'b1};
  assign w_p2_inc = {1'b0, r_p2_pts} + {{SCORE_W{1'b0}}, 1'b1};

  // Delay the score levels by one clock to find their rising edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_d <= 1'b0;
      r_p2_d <= 1'b0;
    end else begin
      r_p1_d <= p1score;
      r_p2_d <= p2score;
    end
  end

  // Match sequencing: scoring, hold timing, win detection and serve gating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_PLAY;
      r_hold_cnt <= 8'd0;
      r_p1_pts   <= '0;
      r_p2_pts   <= '0;
      r_serve    <= 1'b0;
      r_winner   <= WIN_NONE;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        ST_PLAY: begin
          // The serve button is passed through only while play is open
          r_serve <= serve_btn;
          if (new_game) begin
            // A restart wins over a score edge in the same cycle; that edge is lost
            r_p1_pts   <= '0;
            r_p2_pts   <= '0;
            r_hold_cnt <= 8'd0;
          end else if (w_e1 && w_e2) begin
            // Both players cannot score at once: count neither and flag it
            r_fault <= 1'b1;
          end else if (w_e1) begin
            r_p1_pts <= w_p1_inc[SCORE_W-1:0];
            if (w_p1_inc == c_win_score) begin
              r_state  <= ST_OVER;
              r_winner <= WIN_P1;
            end else begin
              r_state    <= ST_POINT;
              r_hold_cnt <= 8'd0;
            end
          end else if (w_e2) begin
            r_p2_pts <= w_p2_inc[SCORE_W-1:0];
            if (w_p2_inc == c_win_score) begin
              r_state  <= ST_OVER;
              r_winner <= WIN_P2;
            end else begin
              r_state    <= ST_POINT;
              r_hold_cnt <= 8'd0;
            end
          end
        end

        ST_POINT: begin
          // Score edges are ignored during the hold
          r_serve <= 1'b0;
          if (new_game) begin
            r_p1_pts   <= '0;
            r_p2_pts   <= '0;
            r_hold_cnt <= 8'd0;
            r_state    <= ST_PLAY;
          end else if (tick) begin
            if (r_hold_cnt == c_hold_last) begin
              r_hold_cnt <= 8'd0;
              r_state    <= ST_PLAY;
            end else begin
              r_hold_cnt <= r_hold_cnt + 8'd1;
            end
          end
        end

        ST_OVER: begin
          // Counts stay frozen until a restart; the fault flag outlives the match
          r_serve <= 1'b0;
          if (new_game) begin
            r_p1_pts   <= '0;
            r_p2_pts   <= '0;
            r_hold_cnt <= 8'd0;
            r_winner   <= WIN_NONE;
            r_state    <= ST_PLAY;
          end
        end

        default: begin
          // Unused encoding: recover into open play
          r_serve <= 1'b0;
          r_state <= ST_PLAY;
        end
      endcase
    end
  end

  assign serve     = r_serve;
  assign p1_pts    = r_p1_pts;
  assign p2_pts    = r_p2_pts;
  assign winner    = r_winner;
  assign fault     = r_fault;
  assign game_over = (r_state == ST_OVER);

endmodule
`default_nettype wire
